// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB per instruction,
// drives datapath controls combinationally from state and the latched opcode.
module multicycle_cu #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_read,
  output logic                ir_write,
  output logic                pc_write,
  output logic                RegDest,
  output logic                Jump,
  output logic                Branch,
  output logic                Sig_Mem_Read,
  output logic                Sig_Mem_to_Reg,
  output logic                Sig_Mem_Write,
  output logic                ALUSrc,
  output logic                Sig_Reg_Write,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                illegal_op,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0011;
  localparam logic [3:0] OP_LD  = 4'b1000;
  localparam logic [3:0] OP_SD  = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1110;
  localparam logic [3:0] OP_LDI = 4'b0111;
  localparam logic [3:0] OP_JMP = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_NOT = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          op4;
  logic                retire;

  assign op4           = op_q[3:0];
  assign state         = state_q;
  assign retired_count = cnt_q;

  // Any bit set above the 4-bit encoding space makes the opcode undefined.
  function automatic logic is_legal(input logic [OPCODE_W-1:0] o);
    logic ok;
    case (o[3:0])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
      OP_LD, OP_SD, OP_BNE, OP_LDI, OP_JMP: ok = 1'b1;
      default:                              ok = 1'b0;
    endcase
    return ok && ((o >> 4) == '0);
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] o);
    logic [2:0] a;
    case (o)
      OP_SUB, OP_BNE, OP_LDI: a = ALU_SUB;
      OP_AND:                 a = ALU_AND;
      OP_NOT:                 a = ALU_NOT;
      OP_OR:                  a = ALU_OR;
      default:                a = ALU_ADD;
    endcase
    return a;
  endfunction

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    retire         = 1'b0;
    imem_read      = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    RegDest        = 1'b0;
    Jump           = 1'b0;
    Branch         = 1'b0;
    Sig_Mem_Read   = 1'b0;
    Sig_Mem_to_Reg = 1'b0;
    Sig_Mem_Write  = 1'b0;
    ALUSrc         = 1'b0;
    Sig_Reg_Write  = 1'b0;
    ALUOp          = '0;
    illegal_op     = 1'b0;

    // Unreachable encodings recover to FETCH even while frozen.
    if (state_q > S_WB) state_d = S_FETCH;

    if (en && !rst) begin
      case (state_q)
        S_FETCH: begin
          imem_read = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          op_d = opcode;
          if (!is_legal(opcode)) begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          ALUOp = ALUOP_W'(alu_of(op4));
          case (op4)
            OP_LD, OP_SD: begin
              ALUSrc  = 1'b1;
              state_d = S_MEM;
            end
            OP_LDI: begin
              ALUSrc  = 1'b1;
              state_d = S_WB;
            end
            OP_BNE: begin
              Branch   = 1'b1;
              pc_write = ~zero;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end
            OP_JMP: begin
              Jump     = 1'b1;
              pc_write = 1'b1;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end
            default: state_d = S_WB;
          endcase
        end
        S_MEM: begin
          // Address path held steady until the data memory completes.
          ALUSrc        = 1'b1;
          ALUOp         = '0;
          Sig_Mem_Read  = (op4 == OP_LD);
          Sig_Mem_Write = (op4 != OP_LD);
          if (dmem_ready) begin
            if (op4 == OP_LD) begin
              state_d = S_WB;
            end else begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          end
        end
        S_WB: begin
          Sig_Reg_Write  = 1'b1;
          RegDest        = (op4 == OP_LD) || (op4 == OP_LDI);
          Sig_Mem_to_Reg = (op4 == OP_LD);
          retire         = 1'b1;
          state_d        = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end

    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
